// File: rtl/vmem_arb.sv
// Single-port video memory arbiter: scan-out reads always win, writer traffic waits in a small FIFO.
// Optional macro VMEM_ARB_FWD_EN forwards the newest pending FIFO write to a matching read.
module vmem_arb #(
  parameter int AW         = 19,
  parameter int DW         = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [AW-1:0] fifo_addr [FIFO_DEPTH];
  logic [DW-1:0] fifo_data [FIFO_DEPTH];
  logic [PW:0]   wr_ptr_reg, rd_ptr_reg;
  logic          empty, full, push, pop, issue_rd;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;

  logic          rd_pend_reg, rd_valid_reg;
  logic [DW-1:0] rd_data_reg;

  // Extra wrap bit on each pointer distinguishes full from empty.
  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign full      = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                     (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
  assign wr_ready  = !reset && !full;
  assign push      = wr_valid && wr_ready;
  assign issue_rd  = !reset && rd_req;
  assign pop       = !reset && !rd_req && !empty;
  assign head_addr = fifo_addr[rd_ptr_reg[PW-1:0]];
  assign head_data = fifo_data[rd_ptr_reg[PW-1:0]];

  always_comb begin
    mem_en    = issue_rd || pop;
    mem_we    = pop;
    mem_addr  = '0;
    mem_wdata = '0;
    if (issue_rd) begin
      mem_addr = rd_addr;
    end else if (pop) begin
      mem_addr  = head_addr;
      mem_wdata = head_data;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr[wr_ptr_reg[PW-1:0]] <= wr_addr;
      fifo_data[wr_ptr_reg[PW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

`ifdef VMEM_ARB_FWD_EN
  logic [PW:0]           count;
  logic [PW-1:0]         slot [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] match;
  logic                  fwd_hit, fwd_hit_reg;
  logic [DW-1:0]         fwd_data, fwd_data_reg;

  assign count = wr_ptr_reg - rd_ptr_reg;

  // Offset gi counts from the oldest entry, so the highest matching offset is the newest write.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_match
    assign slot[gi]  = rd_ptr_reg[PW-1:0] + PW'(gi);
    assign match[gi] = ((PW+1)'(gi) < count) && (fifo_addr[slot[gi]] == rd_addr);
  end

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      if (match[k]) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_data[slot[k]];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fwd_hit_reg  <= 1'b0;
      fwd_data_reg <= '0;
    end else begin
      fwd_hit_reg  <= issue_rd && fwd_hit;
      fwd_data_reg <= fwd_data;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_pend_reg  <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      rd_pend_reg  <= issue_rd;
      rd_valid_reg <= rd_pend_reg;
      if (rd_pend_reg) begin
`ifdef VMEM_ARB_FWD_EN
        rd_data_reg <= fwd_hit_reg ? fwd_data_reg : mem_rdata;
`else
        rd_data_reg <= mem_rdata;
`endif
      end
    end
  end

  // Masked during reset so nothing surfaces from a pipeline that is being flushed.
  assign rd_valid = rd_valid_reg && !reset;
  assign rd_data  = reset ? '0 : rd_data_reg;

endmodule

// File: tb/tb_vmem_arb.sv
// Directed bench for vmem_arb with a one-cycle-latency memory model on the shared port.
// Checks reset, read latency, FIFO ordering/full handling, forwarding, mid-run reset, and interleave.
module tb_vmem_arb;

  logic        clock = 1'b0;
  logic        reset;
  logic        rd_req;
  logic [18:0] rd_addr;
  logic [23:0] rd_data;
  logic        rd_valid;
  logic        wr_valid;
  logic        wr_ready;
  logic [18:0] wr_addr;
  logic [23:0] wr_data;
  logic        mem_en;
  logic        mem_we;
  logic [18:0] mem_addr;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata = 24'h0;

  int total = 0;
  int bad   = 0;
  int we_cnt = 0;
  int rv_cnt = 0;

  logic [23:0] mem_model [256];

  bit rd_pat [10] = '{1, 1, 1, 0, 1, 0, 1, 0, 0, 0};
  bit exp_we [10] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 0};

  vmem_arb dut (
    .clock    (clock),
    .reset    (reset),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Memory model: read data appears the cycle after the read is issued.
  always @(posedge clock) begin
    if (mem_en && mem_we) mem_model[mem_addr[7:0]] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem_model[mem_addr[7:0]];
    if (mem_we) we_cnt <= we_cnt + 1;
    if (rd_valid) rv_cnt <= rv_cnt + 1;
  end

  task automatic cyc;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; rd_req = 1'b0; rd_addr = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    cyc(); cyc(); #2;
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL rst_wr_ready got=%b exp=0", wr_ready); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid got=%b exp=0", rd_valid); end
    total++; if (rd_data !== 24'h0) begin bad++; $display("FAIL rst_rd_data got=%h exp=0", rd_data); end
    total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL rst_mem_en got=%b exp=0", mem_en); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
    total++; if (mem_addr !== 19'h0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    cyc(); reset = 1'b0; #2;
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", wr_ready); end
    total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL rst_idle_en got=%b exp=0", mem_en); end
    $display("test_reset done");
  endtask

  task automatic test_read_latency;
    cyc(); rd_req = 1'b1; rd_addr = 19'h10; #2;
    total++; if ({mem_en, mem_we} !== 2'b10) begin bad++; $display("FAIL lat_issue en_we got=%b exp=10", {mem_en, mem_we}); end
    total++; if (mem_addr !== 19'h10) begin bad++; $display("FAIL lat_issue_addr got=%h exp=10", mem_addr); end
    cyc(); rd_req = 1'b0; #2;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL lat_n1_valid got=%b exp=0", rd_valid); end
    cyc(); #2;
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL lat_n2_valid got=%b exp=1", rd_valid); end
    total++; if (rd_data !== 24'hABCDEF) begin bad++; $display("FAIL lat_n2_data got=%h exp=abcdef", rd_data); end
    cyc(); #2;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL lat_n3_valid got=%b exp=0", rd_valid); end
    $display("test_read_latency done");
  endtask

  task automatic test_fill_drain;
    rd_req = 1'b1; rd_addr = 19'h20;
    for (int i = 0; i < 4; i++) begin
      cyc(); wr_valid = 1'b1; wr_addr = 19'(i + 1); wr_data = 24'(8'h11 * (i + 1)); #2;
      total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL fill_ready%0d got=%b exp=1", i, wr_ready); end
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL fill_we%0d got=%b exp=0", i, mem_we); end
      total++; if (mem_wdata !== 24'h0) begin bad++; $display("FAIL fill_wdata%0d got=%h exp=0", i, mem_wdata); end
    end
    for (int i = 0; i < 2; i++) begin
      cyc(); wr_valid = 1'b0; #2;
      total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL full_ready%0d got=%b exp=0", i, wr_ready); end
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL held_we%0d got=%b exp=0", i, mem_we); end
    end
    for (int i = 0; i < 4; i++) begin
      cyc(); rd_req = 1'b0; #2;
      total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL drain_we%0d got=%b exp=1", i, mem_we); end
      total++; if (mem_addr !== 19'(i + 1)) begin bad++; $display("FAIL drain_addr%0d got=%h exp=%h", i, mem_addr, i + 1); end
      total++; if (mem_wdata !== 24'(8'h11 * (i + 1))) begin bad++; $display("FAIL drain_data%0d got=%h exp=%h", i, mem_wdata, 8'h11 * (i + 1)); end
    end
    cyc(); #2;
    total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL drain_empty_en got=%b exp=0", mem_en); end
    $display("test_fill_drain done");
  endtask

  task automatic test_full_pop;
    rd_req = 1'b1; rd_addr = 19'h21;
    for (int i = 0; i < 4; i++) begin
      cyc(); wr_valid = 1'b1; wr_addr = 19'(i + 1); wr_data = 24'hA0 + 24'(i + 1);
    end
    cyc(); rd_req = 1'b0; wr_valid = 1'b1; wr_addr = 19'h5; wr_data = 24'h55; #2;
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL fp_pop_ready got=%b exp=0", wr_ready); end
    total++; if (mem_we !== 1'b1 || mem_addr !== 19'h1) begin bad++; $display("FAIL fp_pop1 got=%b/%h exp=1/1", mem_we, mem_addr); end
    cyc(); #2;
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL fp_next_ready got=%b exp=1", wr_ready); end
    total++; if (mem_addr !== 19'h2) begin bad++; $display("FAIL fp_pop2 got=%h exp=2", mem_addr); end
    cyc(); wr_valid = 1'b0;
    for (int i = 3; i <= 5; i++) begin
      if (i > 3) cyc();
      #2;
      total++; if (mem_we !== 1'b1 || mem_addr !== 19'(i)) begin bad++; $display("FAIL fp_pop%0d got=%b/%h exp=1/%h", i, mem_we, mem_addr, i); end
    end
    total++; if (mem_wdata !== 24'h55) begin bad++; $display("FAIL fp_last_data got=%h exp=55", mem_wdata); end
    cyc(); #2;
    total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL fp_empty_en got=%b exp=0", mem_en); end
    $display("test_full_pop done");
  endtask

  task automatic test_forward;
    logic [23:0] exp_d;
`ifdef VMEM_ARB_FWD_EN
    exp_d = 24'h123456;
`else
    exp_d = 24'hA50007;
`endif
    cyc(); rd_req = 1'b1; rd_addr = 19'h30; wr_valid = 1'b1; wr_addr = 19'h7; wr_data = 24'h123456;
    cyc(); wr_valid = 1'b0; rd_addr = 19'h7; #2;
    total++; if (mem_we !== 1'b0 || mem_addr !== 19'h7) begin bad++; $display("FAIL fwd_read_issue got=%b/%h exp=0/7", mem_we, mem_addr); end
    cyc(); rd_req = 1'b0; #2;
    total++; if (mem_we !== 1'b1 || mem_wdata !== 24'h123456) begin bad++; $display("FAIL fwd_drain got=%b/%h exp=1/123456", mem_we, mem_wdata); end
    total++; if (rd_valid !== 1'b1 || rd_data !== 24'hA50030) begin bad++; $display("FAIL fwd_prev_read got=%b/%h exp=1/a50030", rd_valid, rd_data); end
    cyc(); #2;
    total++; if (rd_valid !== 1'b1 || rd_data !== exp_d) begin bad++; $display("FAIL fwd_data got=%b/%h exp=1/%h", rd_valid, rd_data, exp_d); end
    cyc(); rd_req = 1'b1; rd_addr = 19'h7; #2;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL fwd_gap_valid got=%b exp=0", rd_valid); end
    cyc(); rd_req = 1'b0;
    cyc(); #2;
    total++; if (rd_valid !== 1'b1 || rd_data !== 24'h123456) begin bad++; $display("FAIL fwd_reread got=%b/%h exp=1/123456", rd_valid, rd_data); end
    $display("test_forward done");
  endtask

  task automatic test_reset_mid;
    int we0, rv0;
    for (int i = 0; i < 3; i++) begin
      cyc(); rd_req = 1'b1; rd_addr = 19'h50 + 19'(i); wr_valid = 1'b1; wr_addr = 19'h8 + 19'(i); wr_data = 24'hC0 + 24'(i);
    end
    cyc(); reset = 1'b1; rd_req = 1'b0; wr_valid = 1'b0; #2;
    we0 = we_cnt; rv0 = rv_cnt;
    total++; if (rd_valid !== 1'b0 || rd_data !== 24'h0) begin bad++; $display("FAIL mid_rst_rd got=%b/%h exp=0/0", rd_valid, rd_data); end
    total++; if (mem_en !== 1'b0 || wr_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_mem got=%b/%b exp=0/0", mem_en, wr_ready); end
    cyc();
    cyc(); reset = 1'b0; #2;
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL mid_release_ready got=%b exp=1", wr_ready); end
    for (int i = 0; i < 5; i++) begin
      cyc(); #2;
      total++; if (mem_we !== 1'b0 || rd_valid !== 1'b0) begin bad++; $display("FAIL mid_after%0d we/valid got=%b/%b exp=0/0", i, mem_we, rd_valid); end
    end
    total++; if (we_cnt !== we0 || rv_cnt !== rv0) begin bad++; $display("FAIL mid_counts got=%0d/%0d exp=%0d/%0d", we_cnt, rv_cnt, we0, rv0); end
    $display("test_reset_mid done");
  endtask

  task automatic test_alternate;
    int k;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      rd_req = rd_pat[c]; rd_addr = 19'h40 + 19'(c);
      wr_valid = (c < 2); wr_addr = 19'h60 + 19'(c); wr_data = 24'hBB0000 + 24'(c);
      #2;
      total++; if (mem_we !== exp_we[c]) begin bad++; $display("FAIL alt_we c%0d got=%b exp=%b", c, mem_we, exp_we[c]); end
      if (exp_we[c]) begin
        total++; if (mem_addr !== 19'h60 + 19'(k) || mem_wdata !== 24'hBB0000 + 24'(k)) begin bad++; $display("FAIL alt_wr c%0d got=%h/%h exp=%h/%h", c, mem_addr, mem_wdata, 19'h60 + 19'(k), 24'hBB0000 + 24'(k)); end
        k++;
      end
      if (c >= 2) begin
        total++; if (rd_valid !== rd_pat[c-2]) begin bad++; $display("FAIL alt_valid c%0d got=%b exp=%b", c, rd_valid, rd_pat[c-2]); end
        if (rd_pat[c-2]) begin
          total++; if (rd_data !== 24'hA50040 + 24'(c - 2)) begin bad++; $display("FAIL alt_data c%0d got=%h exp=%h", c, rd_data, 24'hA50040 + 24'(c - 2)); end
        end
      end
    end
    $display("test_alternate done");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = 24'hA50000 + 24'(i);
    mem_model[8'h10] = 24'hABCDEF;
    test_reset();
    test_read_latency();
    test_fill_drain();
    test_full_pop();
    test_forward();
    test_reset_mid();
    test_alternate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
